stroke_painter: RTL and testbench
=================================

Name: stroke_painter

Overview:
- Consumes the stroke control-point stream produced by the stroke generator: one (x,y) point per handshake plus a last flag.
- Rasterises a filled disc of radius R in the stroke colour around each point and issues pixel writes to the canvas framebuffer write port.
- Sits between the stroke generator and the canvas memory controller.
- Owns disc scan order, canvas clipping and write backpressure.

Parameters:
- MAX_R, 8, largest supported brush radius; larger i_R is clamped to this value.
- IMG_W, 640, canvas width in pixels; valid x is 0..IMG_W-1.
- IMG_H, 480, canvas height in pixels; valid y is 0..IMG_H-1.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  one-cycle pulse; latches i_R and i_color and begins a stroke. Only honoured in IDLE.
- i_R  input  4  brush radius.
- i_color  input  24  stroke colour, {R,G,B} 8 bits each.
- i_pt_valid  input  1  control point valid.
- o_pt_ready  output  1  painter can accept a point.
- i_pt_x  input  10  point x (unsigned).
- i_pt_y  input  10  point y (unsigned).
- i_pt_last  input  1  marks the final point of the stroke.
- o_wr_en  output  1  pixel write request.
- o_wr_x  output  10  write x.
- o_wr_y  output  10  write y.
- o_wr_data  output  24  write colour; always equals the latched colour.
- i_wr_ready  input  1  framebuffer accepts the write this cycle.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse when the stroke completes.

Behaviour:
- Reset: on i_rst high at a clock edge:
  - state goes to IDLE;
  - o_pt_ready, o_wr_en, o_busy and o_done go to 0;
  - o_wr_x, o_wr_y and o_wr_data go to 0;
  - scan counters and the latched R, colour, centre and last flag are cleared;
  - any in-flight write is dropped, including mid-scan.
- States: IDLE, WAIT_PT, SCAN, DONE.
- IDLE:
  - On i_start, latch Rl = min(i_R, MAX_R) and the colour, then go to WAIT_PT.
  - i_start outside IDLE is ignored.
- WAIT_PT:
  - o_pt_ready = 1.
  - On i_pt_valid && o_pt_ready, latch centre (cx,cy) and last, set dy = -Rl and dx = -Rl, then go to SCAN.
  - o_pt_ready is 0 in all other states.
- SCAN, candidate selection:
  - One candidate (dx,dy) is examined per advance.
  - Order: dy outer loop ascending, dx inner loop ascending, each over -Rl..+Rl.
  - Candidate pixel is px = cx+dx, py = cy+dy, computed as 12-bit signed values.
- SCAN, write condition:
  - o_wr_en = (dx*dx + dy*dy <= Rl*Rl) && (0 <= px < IMG_W) && (0 <= py < IMG_H).
  - Squares use unsigned magnitudes; the sum is 8 bits wide.
- SCAN, output timing:
  - o_wr_en, o_wr_x, o_wr_y and o_wr_data are decoded from registered state only.
  - There is no combinational path from i_wr_ready to any output.
  - The first candidate is presented the cycle after point acceptance.
- SCAN, advance rule:
  - Counters advance when !o_wr_en || i_wr_ready.
  - Rejected (outside-disc or clipped) candidates therefore consume exactly one cycle.
  - While o_wr_en && !i_wr_ready, all write outputs are held stable.
- SCAN, cycle count: with i_wr_ready tied high, SCAN lasts exactly (2Rl+1)^2 cycles per point.
- SCAN, exit: when the candidate (dx,dy) = (+Rl,+Rl) advances, go to DONE if last is set, otherwise go to WAIT_PT.
- DONE: o_done = 1 for exactly one cycle, then go to IDLE.
- Rl = 0 produces a single candidate, the centre pixel, in 1 cycle.
- No deduplication: overlapping discs from consecutive points rewrite the shared pixels.
- Throughput: at most one write per cycle. Between points there is one WAIT_PT cycle minimum.

Test Plan:
- Single-pixel brush: start with R=0, colour 0xFF0000; point (5,7) with last=1 -> exactly one write (5,7,0xFF0000), then o_done pulses 1 cycle later, then o_busy returns to 0.
- Radius 1, wr_ready high: point (10,10) -> writes in order (10,9), (9,10), (10,10), (11,10), (10,11) over 9 SCAN cycles; o_pt_ready returns the cycle after SCAN if last=0.
- Corner clipping: R=2, point (0,0) -> exactly 6 writes, in order (0,0), (1,0), (2,0), (0,1), (1,1), (0,2); no write with negative or wrapped coordinates. Likewise point (639,479) never writes x>639 or y>479.
- Backpressure: R=1 at (10,10); hold i_wr_ready low for 3 cycles on the first write -> (10,9) held stable for 4 cycles; total write sequence unchanged; SCAN takes 12 cycles.
- Clamp and ignored start: i_R=15 with MAX_R=8 -> 17x17 = 289 scan cycles; a pulse of i_start mid-scan changes nothing.
- Reset mid-operation: assert i_rst during SCAN of R=3 -> next cycle all outputs are 0 and state is IDLE; a subsequent normal stroke completes correctly.

Source files
------------

// File: rtl/stroke_painter.sv
// Stroke painter: paints a filled disc of the latched brush radius around each
// incoming control point and streams canvas-clipped pixel writes with backpressure.
module stroke_painter #(
    parameter int MAX_R = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [3:0]  i_R,
    input  logic [23:0] i_color,
    input  logic        i_pt_valid,
    output logic        o_pt_ready,
    input  logic [9:0]  i_pt_x,
    input  logic [9:0]  i_pt_y,
    input  logic        i_pt_last,
    output logic        o_wr_en,
    output logic [9:0]  o_wr_x,
    output logic [9:0]  o_wr_y,
    output logic [23:0] o_wr_data,
    input  logic        i_wr_ready,
    output logic        o_busy,
    output logic        o_done
);
    // state   | meaning
    // IDLE    | waiting for i_start
    // WAIT_PT | ready to accept the next control point
    // SCAN    | stepping disc candidates, one per advance
    // DONE    | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, WAIT_PT, SCAN, DONE} state_t;

    localparam logic [3:0]  MAX_R_L = 4'(MAX_R);
    localparam logic [10:0] W_LIM   = 11'(IMG_W);
    localparam logic [10:0] H_LIM   = 11'(IMG_H);

    state_t            state;
    logic [3:0]        rl;
    logic [9:0]        cx, cy;
    logic              last;
    logic signed [4:0] dx, dy;

    logic signed [4:0] rl_s, neg_rl, nxt_dx, nxt_dy, c_dx, c_dy;
    logic [9:0]        c_cx, c_cy;
    logic [3:0]        mag_x, mag_y;
    logic [7:0]        dist2, r2;
    logic [11:0]       px, py;
    logic              scan_end, advance, c_en;

    // The next candidate is evaluated ahead of time so the write outputs can be registered.
    always_comb begin
        rl_s     = $signed({1'b0, rl});
        neg_rl   = -rl_s;
        scan_end = (dx == rl_s) && (dy == rl_s);
        advance  = !o_wr_en || i_wr_ready;
        if (dx == rl_s) begin
            nxt_dx = neg_rl;
            nxt_dy = dy + 5'sd1;
        end else begin
            nxt_dx = dx + 5'sd1;
            nxt_dy = dy;
        end
        if (state == WAIT_PT) begin
            c_cx = i_pt_x;
            c_cy = i_pt_y;
            c_dx = neg_rl;
            c_dy = neg_rl;
        end else begin
            c_cx = cx;
            c_cy = cy;
            c_dx = nxt_dx;
            c_dy = nxt_dy;
        end
        mag_x = c_dx[4] ? 4'(-c_dx) : c_dx[3:0];
        mag_y = c_dy[4] ? 4'(-c_dy) : c_dy[3:0];
        dist2 = {4'd0, mag_x} * {4'd0, mag_x} + {4'd0, mag_y} * {4'd0, mag_y};
        r2    = {4'd0, rl} * {4'd0, rl};
        px    = {2'b00, c_cx} + {{7{c_dx[4]}}, c_dx};
        py    = {2'b00, c_cy} + {{7{c_dy[4]}}, c_dy};
        // Bit 11 set means the offset took the coordinate below zero.
        c_en  = (dist2 <= r2) && !px[11] && (px[10:0] < W_LIM)
                              && !py[11] && (py[10:0] < H_LIM);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            rl         <= '0;
            cx         <= '0;
            cy         <= '0;
            last       <= 1'b0;
            dx         <= '0;
            dy         <= '0;
            o_pt_ready <= 1'b0;
            o_wr_en    <= 1'b0;
            o_wr_x     <= '0;
            o_wr_y     <= '0;
            o_wr_data  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        rl         <= (i_R > MAX_R_L) ? MAX_R_L : i_R;
                        o_wr_data  <= i_color;
                        o_busy     <= 1'b1;
                        o_pt_ready <= 1'b1;
                        state      <= WAIT_PT;
                    end
                end
                WAIT_PT: begin
                    if (i_pt_valid) begin
                        cx         <= i_pt_x;
                        cy         <= i_pt_y;
                        last       <= i_pt_last;
                        dx         <= neg_rl;
                        dy         <= neg_rl;
                        o_pt_ready <= 1'b0;
                        o_wr_en    <= c_en;
                        o_wr_x     <= px[9:0];
                        o_wr_y     <= py[9:0];
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (advance) begin
                        if (scan_end) begin
                            o_wr_en <= 1'b0;
                            if (last) begin
                                o_done <= 1'b1;
                                state  <= DONE;
                            end else begin
                                o_pt_ready <= 1'b1;
                                state      <= WAIT_PT;
                            end
                        end else begin
                            dx      <= nxt_dx;
                            dy      <= nxt_dy;
                            o_wr_en <= c_en;
                            o_wr_x  <= px[9:0];
                            o_wr_y  <= py[9:0];
                        end
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stroke_painter.sv
// Bench for stroke_painter: directed and random strokes checked against a
// disc-and-clip reference model of the expected pixel write stream.
module tb_stroke_painter;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [3:0]  i_R = '0;
    logic [23:0] i_color = '0;
    logic        i_pt_valid = 1'b0;
    logic [9:0]  i_pt_x = '0;
    logic [9:0]  i_pt_y = '0;
    logic        i_pt_last = 1'b0;
    logic        i_wr_ready = 1'b1;
    logic        o_pt_ready, o_wr_en, o_busy, o_done;
    logic [9:0]  o_wr_x, o_wr_y;
    logic [23:0] o_wr_data;

    stroke_painter dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_R(i_R), .i_color(i_color),
        .i_pt_valid(i_pt_valid), .o_pt_ready(o_pt_ready), .i_pt_x(i_pt_x), .i_pt_y(i_pt_y),
        .i_pt_last(i_pt_last), .o_wr_en(o_wr_en), .o_wr_x(o_wr_x), .o_wr_y(o_wr_y),
        .o_wr_data(o_wr_data), .i_wr_ready(i_wr_ready), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [43:0] exp_q[$];
    logic [43:0] got_q[$];
    int          stalls = 0;
    int          rdy_mode = 0;
    int          stall_left = 0;
    logic        prev_stall = 1'b0;
    logic [43:0] prev_w = '0;
    int          pts_x[4];
    int          pts_y[4];

    // Reference: every offset in the square whose squared distance fits the radius, kept if on canvas.
    function automatic void add_disc(input int rl, input int x, input int y, input logic [23:0] c);
        for (int ddy = -rl; ddy <= rl; ddy++)
            for (int ddx = -rl; ddx <= rl; ddx++)
                if (ddx * ddx + ddy * ddy <= rl * rl && x + ddx >= 0 && x + ddx < 640 &&
                    y + ddy >= 0 && y + ddy < 480)
                    exp_q.push_back({10'(x + ddx), 10'(y + ddy), c});
    endfunction

    always @(negedge i_clk) begin
        if (i_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("hold", {o_wr_en, o_wr_x, o_wr_y, o_wr_data}, {1'b1, prev_w});
            prev_stall = o_wr_en && !i_wr_ready;
            if (o_wr_en && i_wr_ready) got_q.push_back({o_wr_x, o_wr_y, o_wr_data});
            if (prev_stall) begin
                stalls++;
                prev_w = {o_wr_x, o_wr_y, o_wr_data};
            end
        end
    end

    always @(posedge i_clk) begin
        #1;
        case (rdy_mode)
            0: i_wr_ready = 1'b1;
            1: i_wr_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (o_wr_en && stall_left > 0) begin
                    i_wr_ready = 1'b0;
                    stall_left--;
                end else begin
                    i_wr_ready = 1'b1;
                end
            end
        endcase
    end

    task automatic run_stroke(input int r, input logic [23:0] col, input int n, input int mode, input bit poke);
        int rl, c, s0;
        rl = (r > 8) ? 8 : r;
        exp_q.delete();
        got_q.delete();
        rdy_mode   = mode;
        stall_left = 3;
        @(posedge i_clk); #1;
        i_start = 1'b1;
        i_R     = 4'(r);
        i_color = col;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        chk("busy_after_start", o_busy, 1);
        for (int p = 0; p < n; p++) begin
            add_disc(rl, pts_x[p], pts_y[p], col);
            i_pt_valid = 1'b1;
            i_pt_x     = 10'(pts_x[p]);
            i_pt_y     = 10'(pts_y[p]);
            i_pt_last  = (p == n - 1);
            c = 0;
            while (!o_pt_ready && c < 50) begin
                @(posedge i_clk); #1;
                c++;
            end
            chk("pt_ready", o_pt_ready, 1);
            @(posedge i_clk); #1;
            i_pt_valid = 1'b0;
            s0 = stalls;
            c = 0;
            while (!o_pt_ready && !o_done && c < 1500) begin
                i_start = poke && (c == 100);
                i_R     = 4'd2;
                @(posedge i_clk); #1;
                c++;
            end
            i_start = 1'b0;
            chk("scan_cycles", c, (2 * rl + 1) * (2 * rl + 1) + stalls - s0);
            if (p == n - 1) chk("done_pulse", o_done, 1);
            else            chk("ready_after_scan", o_pt_ready, 1);
        end
        @(posedge i_clk); #1;
        chk("done_one_cycle", o_done, 0);
        chk("idle_not_busy", o_busy, 0);
        chk("n_writes", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("write", got_q[i], exp_q[i]);
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk("reset_outputs", {o_pt_ready, o_wr_en, o_busy, o_done, o_wr_x, o_wr_y, o_wr_data}, 0);

        pts_x[0] = 5;  pts_y[0] = 7;
        run_stroke(0, 24'hFF0000, 1, 0, 1'b0);

        pts_x[0] = 10; pts_y[0] = 10;
        pts_x[1] = 20; pts_y[1] = 15;
        run_stroke(1, 24'h00FF00, 2, 0, 1'b0);

        pts_x[0] = 0;   pts_y[0] = 0;
        pts_x[1] = 639; pts_y[1] = 479;
        run_stroke(2, 24'h0000FF, 2, 0, 1'b0);

        pts_x[0] = 10; pts_y[0] = 10;
        run_stroke(1, 24'h123456, 1, 2, 1'b0);
        chk("stall_count", stalls, 3);

        pts_x[0] = 300; pts_y[0] = 200;
        run_stroke(15, 24'hABCDEF, 1, 0, 1'b1);

        // Reset in the middle of a radius-3 scan.
        rdy_mode = 0;
        @(posedge i_clk); #1;
        i_start = 1'b1; i_R = 4'd3; i_color = 24'h777777;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_pt_valid = 1'b1; i_pt_x = 10'd100; i_pt_y = 10'd100; i_pt_last = 1'b1;
        @(posedge i_clk); #1;
        i_pt_valid = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        chk("busy_mid_scan", o_busy, 1);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("reset_mid_scan", {o_pt_ready, o_wr_en, o_busy, o_done, o_wr_x, o_wr_y, o_wr_data}, 0);
        @(posedge i_clk); #1;
        chk("idle_after_reset", {o_pt_ready, o_busy, o_wr_en}, 0);
        pts_x[0] = 50; pts_y[0] = 60;
        run_stroke(3, 24'h0F0F0F, 1, 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            int np;
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) begin
                pts_x[p] = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 12) : $urandom_range(627, 639);
                pts_y[p] = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 12) : $urandom_range(467, 479);
            end
            run_stroke($urandom_range(0, 12), 24'($urandom), np, 1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
